// File: rtl/control_multi_hs.sv
// Multicycle MIPS control FSM with mem_ready wait states, memory timeout and sticky fault halt.
// Optional CTL_STATS_EN macro adds a 32-bit retired-instruction counter output.
module control_multi_hs #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       halted,
  output logic [1:0] fault_code,
  output logic [3:0] state
`ifdef CTL_STATS_EN
  ,
  output logic [31:0] retired
`endif
);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StRex    = 4'd7,
    StRwb    = 4'd8,
    StBeq    = 4'd9,
    StBne    = 4'd10,
    StJmp    = 4'd11,
    StAex    = 4'd12,
    StAwb    = 4'd13,
    StHalt   = 4'd14
  } state_e;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       pcwritecondne;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctl_t;

  localparam int unsigned CntW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(WAIT_LIMIT);

  state_e          r_state, w_nxt;
  ctl_t            r_ctl, w_ctl;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]      r_fault, w_fault_nxt;
  logic            r_halted, r_op_sw;
  logic            w_wait_state, w_timeout, w_fetch_go;

  assign w_wait_state = (r_state == StFetch) || (r_state == StMemRd) || (r_state == StMemWr);
  assign w_timeout    = (WAIT_LIMIT != 0) && w_wait_state && !mem_ready &&
                        ((r_cnt + 1'b1) == Limit);
  assign w_cnt_nxt    = (w_wait_state && !mem_ready && !w_timeout) ? r_cnt + 1'b1 : '0;
  assign w_fetch_go   = (r_state == StFetch) && mem_ready;

  always_comb begin
    w_nxt       = r_state;
    w_fault_nxt = r_fault;
    unique case (r_state)
      StIdle:   w_nxt = StFetch;
      StFetch:  if (mem_ready) w_nxt = StDecode; else if (w_timeout) w_nxt = StHalt;
      StDecode: begin
        unique case (opcode)
          6'b000000:            w_nxt = StRex;
          6'b100011, 6'b101011: w_nxt = StMemAdr;
          6'b000100:            w_nxt = StBeq;
          6'b000101:            w_nxt = StBne;
          6'b000010:            w_nxt = StJmp;
          6'b001000:            w_nxt = StAex;
          default: begin
            w_nxt       = StHalt;
            w_fault_nxt = 2'b01;
          end
        endcase
      end
      StMemAdr: w_nxt = r_op_sw ? StMemWr : StMemRd;
      StMemRd:  if (mem_ready) w_nxt = StMemWb; else if (w_timeout) w_nxt = StHalt;
      StMemWr:  if (mem_ready) w_nxt = StFetch; else if (w_timeout) w_nxt = StHalt;
      StRex:    w_nxt = StRwb;
      StAex:    w_nxt = StAwb;
      StMemWb, StRwb, StAwb, StBeq, StBne, StJmp: w_nxt = StFetch;
      default:  w_nxt = StHalt;
    endcase
    if (w_timeout) w_fault_nxt = 2'b10;
  end

  // Controls are decoded from the next state so they are registered alongside it.
  always_comb begin
    w_ctl = '0;
    unique case (w_nxt)
      StFetch: begin
        w_ctl.memread = 1'b1;
        w_ctl.alusrcb = 2'b01;
      end
      StDecode: w_ctl.alusrcb = 2'b11;
      StMemAdr, StAex: begin
        w_ctl.alusrca = 1'b1;
        w_ctl.alusrcb = 2'b10;
      end
      StMemRd: begin
        w_ctl.iord    = 1'b1;
        w_ctl.memread = 1'b1;
      end
      StMemWb: begin
        w_ctl.memtoreg = 1'b1;
        w_ctl.regwrite = 1'b1;
      end
      StMemWr: begin
        w_ctl.iord     = 1'b1;
        w_ctl.memwrite = 1'b1;
      end
      StRex: begin
        w_ctl.alusrca = 1'b1;
        w_ctl.aluop   = 2'b10;
      end
      StRwb: begin
        w_ctl.regdst   = 1'b1;
        w_ctl.regwrite = 1'b1;
      end
      StAwb: w_ctl.regwrite = 1'b1;
      StBeq, StBne: begin
        w_ctl.alusrca       = 1'b1;
        w_ctl.aluop         = 2'b01;
        w_ctl.pcsource      = 2'b01;
        w_ctl.pcwritecond   = (w_nxt == StBeq);
        w_ctl.pcwritecondne = (w_nxt == StBne);
      end
      StJmp: begin
        w_ctl.pcwrite  = 1'b1;
        w_ctl.pcsource = 2'b10;
      end
      default: w_ctl = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_ctl    <= '0;
      r_cnt    <= '0;
      r_fault  <= 2'b00;
      r_halted <= 1'b0;
      r_op_sw  <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_ctl    <= w_ctl;
      r_cnt    <= w_cnt_nxt;
      r_fault  <= w_fault_nxt;
      r_halted <= (w_nxt == StHalt);
      if (r_state == StDecode) r_op_sw <= (opcode == 6'b101011);
    end
  end

`ifdef CTL_STATS_EN
  logic [31:0] r_retired;

  // Any entry into FETCH except from IDLE (or FETCH itself) ends an instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retired <= '0;
    end else if (w_nxt == StFetch && r_state != StIdle && r_state != StFetch) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign retired = r_retired;
`endif

  // IRWrite/PCWrite in FETCH follow mem_ready within the same cycle.
  assign PCWrite       = r_ctl.pcwrite | w_fetch_go;
  assign IRWrite       = w_fetch_go;
  assign PCWriteCond   = r_ctl.pcwritecond;
  assign PCWriteCondNE = r_ctl.pcwritecondne;
  assign IorD          = r_ctl.iord;
  assign MemRead       = r_ctl.memread;
  assign MemWrite      = r_ctl.memwrite;
  assign MemtoReg      = r_ctl.memtoreg;
  assign RegWrite      = r_ctl.regwrite;
  assign RegDst        = r_ctl.regdst;
  assign ALUSrcA       = r_ctl.alusrca;
  assign ALUSrcB       = r_ctl.alusrcb;
  assign ALUOp         = r_ctl.aluop;
  assign PCSource      = r_ctl.pcsource;
  assign halted        = r_halted;
  assign fault_code    = r_fault;
  assign state         = r_state;

endmodule

// File: tb/tb_control_multi_hs.sv
// Table-driven bench for control_multi_hs plus hand-written timeout and reset-mid-write sequences.
module tb_control_multi_hs;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegWrite, RegDst, ALUSrcA, halted;
  logic [1:0] ALUSrcB, ALUOp, PCSource, fault_code;
  logic [3:0] state;
`ifdef CTL_STATS_EN
  logic [31:0] retired;
`endif

  always #5 clk = ~clk;

  control_multi_hs #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNE(PCWriteCondNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .halted(halted),
    .fault_code(fault_code), .state(state)
`ifdef CTL_STATS_EN
    , .retired(retired)
`endif
  );

  // {PCWrite,PCWriteCond,PCWriteCondNE,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,
  //  RegDst,ALUSrcA,ALUSrcB,ALUOp,PCSource,halted,fault_code}
  logic [19:0] act;
  assign act = {PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, halted,
                fault_code};

  localparam logic [19:0] CZero = 20'h00000;
  localparam logic [19:0] CFw   = 20'h08080;
  localparam logic [19:0] CFr   = 20'h8A080;
  localparam logic [19:0] CDec  = 20'h00180;
  localparam logic [19:0] CAdr  = 20'h00300;
  localparam logic [19:0] CMrd  = 20'h18000;
  localparam logic [19:0] CMwb  = 20'h01800;
  localparam logic [19:0] CMwr  = 20'h14000;
  localparam logic [19:0] CRex  = 20'h00240;
  localparam logic [19:0] CRwb  = 20'h00C00;
  localparam logic [19:0] CBeq  = 20'h40228;
  localparam logic [19:0] CBne  = 20'h20228;
  localparam logic [19:0] CJmp  = 20'h80010;
  localparam logic [19:0] CAwb  = 20'h00800;
  localparam logic [19:0] CH1   = 20'h00005;
  localparam logic [19:0] CH2   = 20'h00006;

  localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100, OpBne = 6'b000101, OpJ = 6'b000010;
  localparam logic [5:0] OpAddi = 6'b001000, OpIll = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [19:0] ctl;
  } vec_t;

  vec_t vec [38];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  task automatic step(input logic [5:0] op, input logic rdy);
    @(posedge clk);
    #1;
    opcode = op;
    mem_ready = rdy;
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [3:0] st, input logic [19:0] ctl);
    chk(nm, {8'd0, state, act}, {8'd0, st, ctl});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_out("reset_state", 4'd0, CZero);
    reset = 1'b1;
  endtask

  initial begin
    vec[0]  = '{OpR, 1'b1, 4'd1, CFr};
    vec[1]  = '{OpR, 1'b0, 4'd2, CDec};
    vec[2]  = '{6'd0, 1'b0, 4'd7, CRex};
    vec[3]  = '{6'd0, 1'b1, 4'd8, CRwb};
    vec[4]  = '{6'd0, 1'b0, 4'd1, CFw};
    vec[5]  = '{6'd0, 1'b1, 4'd1, CFr};
    vec[6]  = '{OpLw, 1'b0, 4'd2, CDec};
    vec[7]  = '{6'd0, 1'b0, 4'd3, CAdr};
    vec[8]  = '{6'd0, 1'b0, 4'd4, CMrd};
    vec[9]  = '{6'd0, 1'b0, 4'd4, CMrd};
    vec[10] = '{6'd0, 1'b0, 4'd4, CMrd};
    vec[11] = '{6'd0, 1'b1, 4'd4, CMrd};
    vec[12] = '{6'd0, 1'b0, 4'd5, CMwb};
    vec[13] = '{6'd0, 1'b1, 4'd1, CFr};
    vec[14] = '{OpSw, 1'b1, 4'd2, CDec};
    vec[15] = '{6'd0, 1'b0, 4'd3, CAdr};
    vec[16] = '{6'd0, 1'b0, 4'd6, CMwr};
    vec[17] = '{6'd0, 1'b1, 4'd6, CMwr};
    vec[18] = '{6'd0, 1'b1, 4'd1, CFr};
    vec[19] = '{OpBeq, 1'b0, 4'd2, CDec};
    vec[20] = '{6'd0, 1'b0, 4'd9, CBeq};
    vec[21] = '{6'd0, 1'b1, 4'd1, CFr};
    vec[22] = '{OpBne, 1'b0, 4'd2, CDec};
    vec[23] = '{6'd0, 1'b0, 4'd10, CBne};
    vec[24] = '{6'd0, 1'b1, 4'd1, CFr};
    vec[25] = '{OpJ, 1'b0, 4'd2, CDec};
    vec[26] = '{6'd0, 1'b0, 4'd11, CJmp};
    vec[27] = '{6'd0, 1'b1, 4'd1, CFr};
    vec[28] = '{OpAddi, 1'b0, 4'd2, CDec};
    vec[29] = '{6'd0, 1'b0, 4'd12, CAdr};
    vec[30] = '{6'd0, 1'b0, 4'd13, CAwb};
    vec[31] = '{6'd0, 1'b0, 4'd1, CFw};
    vec[32] = '{6'd0, 1'b0, 4'd1, CFw};
    vec[33] = '{6'd0, 1'b0, 4'd1, CFw};
    vec[34] = '{6'd0, 1'b1, 4'd1, CFr};
    vec[35] = '{OpIll, 1'b0, 4'd2, CDec};
    vec[36] = '{6'd0, 1'b1, 4'd14, CH1};
    vec[37] = '{6'd0, 1'b0, 4'd14, CH1};

    do_reset();
    for (int i = 0; i < 38; i++) begin
      step(vec[i].op, vec[i].rdy);
      chk_out($sformatf("vec%0d", i), vec[i].st, vec[i].ctl);
    end
`ifdef CTL_STATS_EN
    chk("retired_after_table", retired, 32'd7);
`endif

    // Fetch timeout: four ready-low cycles then HALT with fault 10, sticky.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(6'd0, 1'b0);
      chk_out($sformatf("tmo_wait%0d", i), 4'd1, CFw);
    end
    for (int i = 0; i < 3; i++) begin
      step(OpR, 1'b1);
      chk_out($sformatf("tmo_halt%0d", i), 4'd14, CH2);
    end

    // Reset pulse in the middle of a store's wait state.
    do_reset();
    step(6'd0, 1'b1);
    step(OpSw, 1'b0);
    step(6'd0, 1'b0);
    step(6'd0, 1'b0);
    chk_out("sw_memwr", 4'd6, CMwr);
    reset = 1'b0;
    #1;
    chk_out("midwr_reset", 4'd0, CZero);
`ifdef CTL_STATS_EN
    chk("midwr_retired", retired, 32'd0);
`endif
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    #1;
    chk_out("midwr_held", 4'd0, CZero);
    reset = 1'b1;
    step(6'd0, 1'b1);
    chk_out("after_reset_fetch", 4'd1, CFr);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/control_multi_hs.md
Name: control_multi_hs

Overview:
Moore FSM that sequences the multicycle MIPS datapath (shared memory, IR, A/B/ALUOut registers) for R-type, lw, sw, beq, bne, j and addi. It adds a mem_ready wait-state handshake, a memory timeout and sticky fault halting.

Parameters:
WAIT_LIMIT, 15, max consecutive mem_ready-low cycles in a memory state before timeout fault; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26], sampled in DECODE
mem_ready  in  1  memory completes current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if Zero (beq)
PCWriteCondNE  out  1  PC load if !Zero (bne)
IorD  out  1  0=PC, 1=ALUOut memory address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  IR load
MemtoReg  out  1  0=ALUOut, 1=MDR write data
RegWrite  out  1  register file write
RegDst  out  1  0=rt, 1=rd
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=4, 10=sext imm, 11=sext imm<<2
ALUOp  out  2  00=add, 01=sub, 10=funct
PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target
halted  out  1  FSM in HALT
fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout
state  out  4  current state encoding (debug)

Behaviour:
- Reset: state=IDLE(0), wait counter=0, fault_code=00; every output 0. IDLE->FETCH unconditionally next cycle.
- Encoding: IDLE0 FETCH1 DECODE2 MEMADR3 MEMRD4 MEMWB5 MEMWR6 REX7 RWB8 BEQ9 BNE10 JMP11 AEX12 AWB13 HALT14. Unlisted outputs are 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready (Mealy-gated). Stays until mem_ready=1, then DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode: 000000->REX, 100011/101011->MEMADR, 000100->BEQ, 000101->BNE, 000010->JMP, 001000->AEX, other->HALT with fault_code=01.
- MEMADR and AEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. MEMADR goes to MEMRD (lw) or MEMWR (sw) using the opcode latched in DECODE; AEX->AWB.
- MEMRD: IorD=1, MemRead=1; on mem_ready->MEMWB. MEMWB: MemtoReg=1, RegDst=0, RegWrite=1 ->FETCH.
- MEMWR: IorD=1, MemWrite=1; on mem_ready->FETCH.
- REX: ALUSrcA=1, ALUSrcB=00, ALUOp=10 ->RWB. RWB: RegDst=1, RegWrite=1 ->FETCH. AWB: RegDst=0, RegWrite=1 ->FETCH.
- BEQ/BNE: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond (BEQ) or PCWriteCondNE (BNE)=1 ->FETCH. JMP: PCWrite=1, PCSource=10 ->FETCH.
- Wait counter: increments each FETCH/MEMRD/MEMWR cycle with mem_ready=0; clears on mem_ready=1 or state exit. If WAIT_LIMIT!=0 and the count reaches WAIT_LIMIT while mem_ready=0 ->HALT, fault_code=10. mem_ready=1 in the limit cycle completes normally.
- HALT: all controls 0, halted=1, fault_code held; exits only on reset.
- Reset asserted mid-instruction: immediate return to IDLE, outputs 0; no partial write completes.

Optional Feature:
CTL_STATS_EN: adds output retired[31:0]. It resets to 0 and increments by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, AWB, BEQ, BNE or JMP, wrapping at 2^32. It freezes in HALT. Without the macro the port and counter are absent.

Test Plan:
- reset low then high, mem_ready=1, opcode=000000 -> state sequence 0,1,2,7,8,1; RegWrite=1 and RegDst=1 only in RWB.
- lw (100011) with mem_ready held low 3 cycles in MEMRD -> MemRead/IorD held 4 cycles, then MEMWB with MemtoReg=1 and RegWrite=1.
- opcode=111111 -> HALT after DECODE, halted=1, fault_code=01, all controls 0 until reset.
- WAIT_LIMIT=4, mem_ready=0 forever in FETCH -> HALT after 4 wait cycles, fault_code=10, IRWrite never asserted.
- bne (000101) -> BNE asserts PCWriteCondNE=1, PCSource=01, ALUOp=01; j (000010) -> PCWrite=1, PCSource=10.
- CTL_STATS_EN, run 5 instructions (sw, beq, j, addi, lw) -> retired=5; reset pulse mid-MEMWR -> retired=0, state=0.
